cam_frame_capture: RTL and testbench
====================================

# cam_frame_capture

Single-shot frame grabber between the MT9V034 parallel pixel port and the byte consumers (UART transmit path). On a START request it discards any frame already in progress and waits for the next frame start. It then captures a WIDTH×HEIGHT window as 8-bit pixels into an internal FIFO and streams them out over a valid/ready byte interface. When the frame has ended and the FIFO has drained, it pulses DONE.

## Interface
- WIDTH, 752: pixels captured per line; excess pixels in a line are dropped.
- HEIGHT, 480: lines captured per frame; excess lines are dropped.
- FIFO_DEPTH, 16: output FIFO entries, power of two, ≥2.
- CLK  in  1  single clock; pixel clock and system clock are the same net.
- RST  in  1  synchronous, active-high reset.
- START  in  1  capture request; sampled only in IDLE.
- CAM_FRAME_VALID  in  1  sensor frame valid.
- CAM_LINE_VALID  in  1  sensor line valid.
- CAM_DATA  in  10  sensor pixel; bits [9:2] are kept.
- OUT_DATA  out  8  pixel byte, valid when OUT_VALID=1.
- OUT_VALID  out  1  byte available.
- OUT_READY  in  1  consumer accepts; a transfer occurs when OUT_VALID & OUT_READY at a rising edge.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at the end of a capture.
- OVERFLOW  out  1  sticky; set when a pixel is dropped because the FIFO is full; cleared by RST or an accepted START.

## Operation
- All three camera inputs pass through one register stage (fv_r, lv_r, d_r) before any other use.
- States:
  - IDLE: START=1 → WAIT_GAP; clear OVERFLOW and the row/column counters.
  - WAIT_GAP: fv_r=0 → WAIT_FRAME. This discards a frame already running when START arrives.
  - WAIT_FRAME: fv_r=1 → CAPTURE.
  - CAPTURE: fv_r=0 → FLUSH.
  - FLUSH: FIFO empty → IDLE, with DONE=1 for that one cycle.
- Capture condition: state=CAPTURE & fv_r & lv_r & col<WIDTH & row<HEIGHT.
  - If the FIFO is not full, push d_r[9:2].
  - If the FIFO is full, drop the pixel and set OVERFLOW.
  - col increments on every fv_r&lv_r cycle in CAPTURE and saturates at WIDTH.
- On a falling edge of lv_r in CAPTURE: row increments (saturating at HEIGHT) and col clears to 0.
  - An lv_r pulse with zero qualifying pixels still counts as a line.
- Short frames (fewer lines or pixels than configured) are not errors. Capture simply ends when fv_r falls.
- Counter widths: col is $clog2(WIDTH+1) bits, row is $clog2(HEIGHT+1) bits. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits with wrap-around; full/empty are decoded from the MSB comparison.
- Simultaneous FIFO push and pop when full: the pop frees an entry, so the push succeeds and no overflow is flagged.
- START outside IDLE is ignored. RST wins over START in the same cycle.

## Timing
- Reset values: OUT_DATA=0, OUT_VALID=0, BUSY=0, DONE=0, OVERFLOW=0, state=IDLE, FIFO empty.
- RST asserted mid-capture: at the next edge, go to IDLE, empty the FIFO and drop all contents. DONE is not pulsed.
- START sampled at edge k → BUSY=1 after edge k.
- Pixel latency: a pixel on CAM_DATA at edge k is registered at k, pushed at k+1, and drives OUT_DATA/OUT_VALID after edge k+2 (a registered output stage fed from the FIFO head).
- Throughput: one byte per cycle in and out with OUT_READY held high.
- OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- DONE is asserted in the cycle after the last byte transfers, or in the cycle after fv_r falls if nothing is pending.

## Test plan
- Nominal frame: WIDTH=2, HEIGHT=3, OUT_READY=1, START while the sensor idles, then a frame with lines (11,12), (21,22), (31,32), each value <<2 on CAM_DATA → OUT_DATA sequence 11,12,21,22,31,32, then exactly one DONE pulse and OVERFLOW=0.
- Ongoing frame ignored: START raised while FRAME_VALID=1 mid-frame → no bytes from that frame; the next full frame yields 11,12,21,22,31,32.
- Window cropping: WIDTH=1, HEIGHT=2, same frame → 11,21 only, then DONE.
- Backpressure/overflow: FIFO_DEPTH=4, OUT_READY=0 during the frame → OVERFLOW=1. Releasing OUT_READY yields 11,12,21,22, then DONE.
- Reset mid-capture: RST pulsed after 3 bytes pushed → all outputs return to reset values, OUT_VALID=0 and no DONE. A new START captures the following frame correctly.
- START while BUSY: a second START during CAPTURE → no effect; a single DONE and 6 bytes.

Source files
------------

// File: rtl/cam_frame_capture_if.sv
// Sensor-side inputs plus the byte stream and status seen by the frame grabber.
interface cam_frame_capture_if;
  logic       start;
  logic       cam_frame_valid;
  logic       cam_line_valid;
  logic [9:0] cam_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       overflow;

  modport slave (
    input  start, cam_frame_valid, cam_line_valid, cam_data, out_ready,
    output out_data, out_valid, busy, done, overflow
  );

  modport master (
    output start, cam_frame_valid, cam_line_valid, cam_data, out_ready,
    input  out_data, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/cam_frame_capture.sv
// Single-shot MT9V034 frame grabber: crops a WIDTH x HEIGHT window into a FIFO
// and streams it out as bytes over valid/ready, pulsing done once drained.
module cam_frame_capture #(
  parameter int WIDTH      = 752,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  cam_frame_capture_if.slave cap_if
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [COL_W-1:0] WIDTH_C  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] HEIGHT_C = ROW_W'(HEIGHT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GAP,
    WAIT_FRAME,
    CAPTURE,
    FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic               fv_q, lv_q, lv_prev_q;
  logic [7:0]         d_q;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      level_after_pop;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               fifo_full, fifo_empty;
  logic               cap_pix, push, pop, drop;
  logic               unused_lsbs;

  // Only the top eight sensor bits are ever forwarded.
  assign unused_lsbs = ^cap_if.cam_data[1:0];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign cap_pix = (state_q == CAPTURE) && fv_q && lv_q &&
                   (col_q < WIDTH_C) && (row_q < HEIGHT_C);
  assign pop     = out_valid_q && cap_if.out_ready;
  assign push    = cap_pix && (!fifo_full || pop);
  assign drop    = cap_pix && fifo_full && !pop;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  // The output register tracks the FIFO head as it stands before this edge's
  // push, so a freshly pushed byte appears one cycle later and is only
  // removed from the FIFO when the consumer takes it.
  assign level_after_pop = (wr_ptr_q - rd_ptr_q) - PW'(pop);
  assign out_valid_d     = (level_after_pop != '0);
  assign out_data_d      = out_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : out_data_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (cap_if.start) begin
          state_d = WAIT_GAP;
          col_d   = '0;
          row_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      WAIT_GAP:   if (!fv_q) state_d = WAIT_FRAME;
      WAIT_FRAME: if (fv_q)  state_d = CAPTURE;
      CAPTURE: begin
        if (!fv_q) state_d = FLUSH;
        if (fv_q && lv_q) begin
          if (col_q != WIDTH_C) col_d = col_q + COL_W'(1);
        end else if (lv_prev_q && !lv_q) begin
          col_d = '0;
          if (row_q != HEIGHT_C) row_d = row_q + ROW_W'(1);
        end
        if (drop) ovf_d = 1'b1;
      end
      FLUSH:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      lv_prev_q   <= 1'b0;
      d_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fv_q        <= cap_if.cam_frame_valid;
      lv_q        <= cap_if.cam_line_valid;
      lv_prev_q   <= lv_q;
      d_q         <= cap_if.cam_data[9:2];
      col_q       <= col_d;
      row_q       <= row_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= d_q;
  end

  assign cap_if.out_data  = out_data_q;
  assign cap_if.out_valid = out_valid_q;
  assign cap_if.busy      = (state_q != IDLE);
  assign cap_if.done      = (state_q == FLUSH) && fifo_empty;
  assign cap_if.overflow  = ovf_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Drives two differently sized grabbers from one sensor stream and checks each
// against a frame-level crop model.
module tb_cam_frame_capture;

  typedef logic [7:0] bq_t [$];

  localparam int BW = 3, BH = 4, BD = 16;
  localparam int SW = 2, SH = 3, SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_t, fv_t, lv_t, sm_rdy, big_rand_rdy;
  logic [9:0] data_t;

  always #5 clk = ~clk;

  cam_frame_capture_if big_if();
  cam_frame_capture_if sm_if();

  assign big_if.start           = start_t;
  assign big_if.cam_frame_valid = fv_t;
  assign big_if.cam_line_valid  = lv_t;
  assign big_if.cam_data        = data_t;
  assign sm_if.start            = start_t;
  assign sm_if.cam_frame_valid  = fv_t;
  assign sm_if.cam_line_valid   = lv_t;
  assign sm_if.cam_data         = data_t;
  assign sm_if.out_ready        = sm_rdy;

  cam_frame_capture #(.WIDTH(BW), .HEIGHT(BH), .FIFO_DEPTH(BD)) u_big (
    .clk_i (clk),
    .rst_i (rst),
    .cap_if(big_if)
  );

  cam_frame_capture #(.WIDTH(SW), .HEIGHT(SH), .FIFO_DEPTH(SD)) u_small (
    .clk_i (clk),
    .rst_i (rst),
    .cap_if(sm_if)
  );

  int   checks = 0, errors = 0;
  int   cyc = 0;
  bq_t  got_big, got_sm;
  int   done_big = 0, done_sm = 0;
  int   first_vld_cyc = -1, first_pix_cyc = -1;
  int   line_len [$];
  logic [9:0] frame_pix [$];
  logic [11:0] snap_big, snap_sm;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    big_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      big_if.out_ready = big_rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Transfers are recorded half a cycle before the edge that performs them.
  initial forever begin
    @(negedge clk);
    if (big_if.out_valid && big_if.out_ready) got_big.push_back(big_if.out_data);
    if (sm_if.out_valid && sm_if.out_ready) got_sm.push_back(sm_if.out_data);
    if (big_if.done) done_big++;
    if (sm_if.done) done_sm++;
    if (sm_if.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    got_big.delete();
    got_sm.delete();
    done_big = 0;
    done_sm = 0;
    first_vld_cyc = -1;
  endtask

  task automatic gen_frame(input int lmin, input int lmax, input int pmin, input int pmax);
    int nl;
    line_len.delete();
    frame_pix.delete();
    nl = $urandom_range(lmin, lmax);
    for (int r = 0; r < nl; r++) begin
      line_len.push_back($urandom_range(pmin, pmax));
      for (int c = 0; c < line_len[r]; c++) frame_pix.push_back(10'($urandom));
    end
  endtask

  task automatic fixed_frame();
    line_len.delete();
    frame_pix.delete();
    for (int r = 1; r <= 3; r++) begin
      line_len.push_back(2);
      for (int c = 1; c <= 2; c++) frame_pix.push_back({8'(r * 10 + c), 2'($urandom)});
    end
  endtask

  function automatic bq_t model_bytes(input int w, input int h);
    bq_t q;
    int idx = 0;
    logic [9:0] p;
    for (int r = 0; r < line_len.size(); r++)
      for (int c = 0; c < line_len[r]; c++) begin
        p = frame_pix[idx];
        if (r < h && c < w) q.push_back(p[9:2]);
        idx++;
      end
    return q;
  endfunction

  function automatic bit same_q(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_pulse();
    start_t = 1'b1;
    step();
    start_t = 1'b0;
  endtask

  // Plays the stored frame; start/rst can be pulsed alongside a chosen pixel.
  task automatic play_frame(input int start_at, input int rst_at);
    int idx = 0;
    fv_t = 1'b1;
    step(2);
    for (int r = 0; r < line_len.size(); r++) begin
      for (int c = 0; c < line_len[r]; c++) begin
        lv_t   = 1'b1;
        data_t = frame_pix[idx];
        if (idx == start_at) start_t = 1'b1;
        if (idx == rst_at) rst = 1'b1;
        if (idx == 0) first_pix_cyc = cyc;
        step();
        start_t = 1'b0;
        if (idx == rst_at) begin
          rst = 1'b0;
          @(negedge clk);
          snap_big = {big_if.out_data, big_if.out_valid, big_if.busy, big_if.done, big_if.overflow};
          snap_sm  = {sm_if.out_data, sm_if.out_valid, sm_if.busy, sm_if.done, sm_if.overflow};
        end
        idx++;
      end
      lv_t   = 1'b0;
      data_t = 10'($urandom);
      step($urandom_range(1, 3));
    end
    fv_t = 1'b0;
    step(3);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((done_big == 0 || done_sm == 0) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (done_big == 0 || done_sm == 0) begin
      errors++;
      $display("FAIL %s_done_timeout big=%0d small=%0d required 1 each", tag, done_big, done_sm);
    end
    step(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_t = 1'b0; fv_t = 1'b0; lv_t = 1'b0; data_t = '0;
    sm_rdy = 1'b1; big_rand_rdy = 1'b0;
    step(3);
    @(negedge clk);
    checks++;
    if ({big_if.out_data, big_if.out_valid, big_if.busy, big_if.done, big_if.overflow} !== 12'h0) begin
      errors++;
      $display("FAIL reset_big data=%0d vld=%b busy=%b done=%b ovf=%b required all 0",
               big_if.out_data, big_if.out_valid, big_if.busy, big_if.done, big_if.overflow);
    end
    checks++;
    if ({sm_if.out_data, sm_if.out_valid, sm_if.busy, sm_if.done, sm_if.overflow} !== 12'h0) begin
      errors++;
      $display("FAIL reset_small data=%0d vld=%b busy=%b done=%b ovf=%b required all 0",
               sm_if.out_data, sm_if.out_valid, sm_if.busy, sm_if.done, sm_if.overflow);
    end
    step();
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_nominal();
    bq_t eb, es;
    clear_obs();
    fixed_frame();
    start_pulse();
    @(negedge clk);
    checks++;
    if ({big_if.busy, sm_if.busy} !== 2'b11) begin
      errors++;
      $display("FAIL nominal_busy got=%b%b required 11", big_if.busy, sm_if.busy);
    end
    step();
    play_frame(-1, -1);
    wait_done("nominal");
    eb = model_bytes(BW, BH);
    es = model_bytes(SW, SH);
    checks++;
    if (first_vld_cyc - first_pix_cyc !== 3) begin
      errors++;
      $display("FAIL nominal_latency got=%0d required 3", first_vld_cyc - first_pix_cyc);
    end
    checks++;
    if (!same_q(got_sm, es)) begin
      errors++;
      $display("FAIL nominal_small_bytes got=%p required=%p", got_sm, es);
    end
    checks++;
    if (!same_q(got_big, eb)) begin
      errors++;
      $display("FAIL nominal_big_bytes got=%p required=%p", got_big, eb);
    end
    checks++;
    if (done_big !== 1 || done_sm !== 1 || big_if.overflow !== 1'b0 || sm_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL nominal_status done=%0d/%0d ovf=%b/%b required 1/1 0/0",
               done_big, done_sm, big_if.overflow, sm_if.overflow);
    end
  endtask

  task automatic test_ongoing();
    bq_t eb, es;
    clear_obs();
    big_rand_rdy = 1'b1;
    gen_frame(2, 4, 2, 4);
    play_frame(1, -1);
    checks++;
    if (got_big.size() != 0 || got_sm.size() != 0 || done_big != 0 || done_sm != 0) begin
      errors++;
      $display("FAIL ongoing_discard bytes=%0d/%0d done=%0d/%0d required 0",
               got_big.size(), got_sm.size(), done_big, done_sm);
    end
    gen_frame(2, 5, 1, 5);
    play_frame(-1, -1);
    wait_done("ongoing");
    eb = model_bytes(BW, BH);
    es = model_bytes(SW, SH);
    checks++;
    if (!same_q(got_sm, es) || !same_q(got_big, eb)) begin
      errors++;
      $display("FAIL ongoing_next_frame small=%p req=%p big=%p req=%p", got_sm, es, got_big, eb);
    end
  endtask

  task automatic test_crop();
    bq_t eb, es;
    for (int it = 0; it < 4; it++) begin
      clear_obs();
      gen_frame(1, 6, 1, 5);
      start_pulse();
      play_frame(-1, -1);
      wait_done("crop");
      eb = model_bytes(BW, BH);
      es = model_bytes(SW, SH);
      checks++;
      if (!same_q(got_sm, es)) begin
        errors++;
        $display("FAIL crop_small it=%0d got=%p required=%p", it, got_sm, es);
      end
      checks++;
      if (!same_q(got_big, eb)) begin
        errors++;
        $display("FAIL crop_big it=%0d got=%p required=%p", it, got_big, eb);
      end
      checks++;
      if (done_big !== 1 || done_sm !== 1 || big_if.overflow !== 1'b0 || sm_if.overflow !== 1'b0) begin
        errors++;
        $display("FAIL crop_status it=%0d done=%0d/%0d ovf=%b/%b required 1/1 0/0",
                 it, done_big, done_sm, big_if.overflow, sm_if.overflow);
      end
    end
  endtask

  task automatic test_overflow();
    bq_t eb, es;
    clear_obs();
    gen_frame(3, 5, 2, 4);
    eb = model_bytes(BW, BH);
    es = model_bytes(SW, SH);
    while (es.size() > SD) void'(es.pop_back());
    sm_rdy = 1'b0;
    start_pulse();
    play_frame(-1, -1);
    step(4);
    @(negedge clk);
    checks++;
    if (sm_if.overflow !== 1'b1 || big_if.overflow !== 1'b0 || sm_if.busy !== 1'b1 || done_sm != 0) begin
      errors++;
      $display("FAIL overflow_flag ovf_small=%b ovf_big=%b busy=%b done=%0d required 1 0 1 0",
               sm_if.overflow, big_if.overflow, sm_if.busy, done_sm);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sm_if.out_valid !== 1'b1 || sm_if.out_data !== es[0]) begin
        errors++;
        $display("FAIL overflow_hold vld=%b data=%0d required 1 %0d", sm_if.out_valid, sm_if.out_data, es[0]);
      end
    end
    step();
    sm_rdy = 1'b1;
    wait_done("overflow");
    checks++;
    if (!same_q(got_sm, es)) begin
      errors++;
      $display("FAIL overflow_small_bytes got=%p required=%p", got_sm, es);
    end
    checks++;
    if (!same_q(got_big, eb) || done_sm != 1) begin
      errors++;
      $display("FAIL overflow_big_bytes got=%p required=%p done_small=%0d", got_big, eb, done_sm);
    end
  endtask

  task automatic test_start_busy();
    bq_t eb, es;
    clear_obs();
    gen_frame(2, 4, 1, 3);
    start_pulse();
    @(negedge clk);
    checks++;
    if (sm_if.overflow !== 1'b0 || big_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_ovf got=%b/%b required 0/0", sm_if.overflow, big_if.overflow);
    end
    step();
    play_frame(0, -1);
    wait_done("start_busy");
    step(10);
    eb = model_bytes(BW, BH);
    es = model_bytes(SW, SH);
    checks++;
    if (!same_q(got_sm, es) || !same_q(got_big, eb)) begin
      errors++;
      $display("FAIL start_busy_bytes small=%p req=%p big=%p req=%p", got_sm, es, got_big, eb);
    end
    checks++;
    if (done_big !== 1 || done_sm !== 1 || big_if.busy !== 1'b0 || sm_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_done done=%0d/%0d busy=%b/%b required 1/1 0/0",
               done_big, done_sm, big_if.busy, sm_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    bq_t eb, es;
    clear_obs();
    gen_frame(2, 3, 5, 6);
    start_pulse();
    play_frame(-1, 4);
    checks++;
    if (snap_big !== 12'h0 || snap_sm !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs big=%h small=%h required 000", snap_big, snap_sm);
    end
    step(10);
    checks++;
    if (done_big != 0 || done_sm != 0 || big_if.busy !== 1'b0 || sm_if.busy !== 1'b0 ||
        got_big.size() > 3 || got_sm.size() > 3) begin
      errors++;
      $display("FAIL reset_mid_quiet done=%0d/%0d busy=%b/%b bytes=%0d/%0d required 0 0 <=3",
               done_big, done_sm, big_if.busy, sm_if.busy, got_big.size(), got_sm.size());
    end
    clear_obs();
    gen_frame(1, 5, 1, 5);
    start_pulse();
    play_frame(-1, -1);
    wait_done("reset_mid");
    eb = model_bytes(BW, BH);
    es = model_bytes(SW, SH);
    checks++;
    if (!same_q(got_sm, es) || !same_q(got_big, eb) || done_big != 1 || done_sm != 1) begin
      errors++;
      $display("FAIL reset_mid_recapture small=%p req=%p big=%p req=%p done=%0d/%0d",
               got_sm, es, got_big, eb, done_big, done_sm);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ongoing();
    test_crop();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
